mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one unified memory port between the instruction-fetch requester (IF, read-only) and the data-memory requester (MEM, read/write). It keeps at most one transaction outstanding and produces the one-cycle done pulses that IF and MEM use as i_IF_Done and i_MEM_Done toward hazard detection. It sits between the pipeline's IF/MEM stages and the external memory controller.

## Interface
- DATA_WIDTH, 32: data bus width
- ADDRESS_WIDTH, 32: address bus width
- STARVE_LIMIT, 4: consecutive MEM grants, with IF pending, before IF is forced (guard build only); must be ≥1
- i_Clk  in  1  sole clock; all logic on rising edge
- i_Reset  in  1  reset; one clock, reset is asynchronous and active-high
- i_IF_Req  in  1  IF read request; held high until o_IF_Done
- i_IF_Addr  in  ADDRESS_WIDTH  IF read address
- o_IF_Done  out  1  one-cycle pulse; o_IF_Rdata valid this cycle
- o_IF_Rdata  out  DATA_WIDTH  fetched instruction
- i_MEM_Req  in  1  MEM request; held high until o_MEM_Done
- i_MEM_Write  in  1  1=write, 0=read
- i_MEM_Addr  in  ADDRESS_WIDTH  data address
- i_MEM_Wdata  in  DATA_WIDTH  write data
- i_MEM_Byte_En  in  DATA_WIDTH/8  write byte enables
- o_MEM_Done  out  1  one-cycle pulse; o_MEM_Rdata valid this cycle for reads
- o_MEM_Rdata  out  DATA_WIDTH  load data
- o_Mem_Valid  out  1  command valid to memory
- i_Mem_Ready  in  1  memory accepts command when o_Mem_Valid && i_Mem_Ready
- o_Mem_Write, o_Mem_Addr, o_Mem_Wdata, o_Mem_Byte_En  out  1/ADDRESS_WIDTH/DATA_WIDTH/DATA_WIDTH/8  command fields, registered
- i_Mem_Resp_Valid  in  1  response for accepted command (read data or write ack)
- i_Mem_Rdata  in  DATA_WIDTH  read data, valid with i_Mem_Resp_Valid

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registered owner bit (IF or MEM) set on grant.
- IDLE: if any request, grant per arbitration; latch command fields (IF → write=0, byte_en all 1, wdata 0); go ISSUE.
- ISSUE: o_Mem_Valid=1, fields stable; on i_Mem_Ready go WAIT.
- WAIT: on i_Mem_Resp_Valid, latch i_Mem_Rdata into owner's Rdata register; go DONE.
- DONE: owner's Done=1 for exactly this cycle; go IDLE. Requester drops or changes its request at this edge, so a stale request is never reissued.
- Arbitration (IDLE, both requesting): MEM wins (older instruction; avoids pipeline deadlock). Single requester always wins.
- Request fields sampled only at grant; changes while busy (e.g. IF redirected by a branch) are ignored; smashing a stale fetch is the hazard logic's job.
- i_Mem_Resp_Valid outside WAIT and i_Mem_Ready outside ISSUE are ignored.
- o_IF_Rdata/o_MEM_Rdata hold last value until next response for that owner; writes leave o_MEM_Rdata unchanged.

## Timing
- Reset (async, immediate): state IDLE; o_Mem_Valid, o_IF_Done, o_MEM_Done = 0; all data/address outputs 0; starve counter 0. Reset mid-transaction abandons it; the memory controller is reset alongside.
- Minimum latency: request seen cycle 0 → o_Mem_Valid cycle 1 → (ready cycle 1, response cycle 2) → Done cycle 3. Next grant earliest cycle 4.
- Each extra cycle of i_Mem_Ready low or response delay adds one cycle; no timeout.
- Done never asserts for both owners in the same cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined: counter increments on each MEM grant made while i_IF_Req high, clears on any IF grant; when count == STARVE_LIMIT and both request in IDLE, IF wins.
- Not defined: strict MEM priority; counter absent.

## Test plan
- IF only, addr 0x100, ready immediate, response next cycle with 0xDEADBEEF → o_Mem_Valid cycle 1, o_IF_Done cycle 3 with o_IF_Rdata=0xDEADBEEF.
- MEM write addr 0x40, data 0x12345678, byte_en 0xF, ready held low 3 cycles → command fields stable throughout ISSUE; o_MEM_Done one cycle after response; o_MEM_Rdata unchanged.
- IF and MEM raised same cycle → MEM granted first; IF granted in IDLE after MEM's DONE; exactly one Done per transaction.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, MEM re-requests continuously with IF pending → 4 MEM transactions, then IF granted; without the macro IF waits until MEM idles.
- Spurious i_Mem_Resp_Valid during IDLE/ISSUE → no Done, no Rdata change.
- i_Reset asserted during WAIT → outputs zero immediately; after release, a new IF request completes normally with no leftover Done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IF (read-only) and MEM (read/write) requesters, one transaction at a time.
// Optional build macro ARB_STARVE_GUARD_EN lets a pending IF request win after STARVE_LIMIT back-to-back MEM grants.
module mem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_IF_Req,
  input  logic [ADDRESS_WIDTH-1:0]  i_IF_Addr,
  output logic                      o_IF_Done,
  output logic [DATA_WIDTH-1:0]     o_IF_Rdata,
  input  logic                      i_MEM_Req,
  input  logic                      i_MEM_Write,
  input  logic [ADDRESS_WIDTH-1:0]  i_MEM_Addr,
  input  logic [DATA_WIDTH-1:0]     i_MEM_Wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_MEM_Byte_En,
  output logic                      o_MEM_Done,
  output logic [DATA_WIDTH-1:0]     o_MEM_Rdata,
  output logic                      o_Mem_Valid,
  input  logic                      i_Mem_Ready,
  output logic                      o_Mem_Write,
  output logic [ADDRESS_WIDTH-1:0]  o_Mem_Addr,
  output logic [DATA_WIDTH-1:0]     o_Mem_Wdata,
  output logic [DATA_WIDTH/8-1:0]   o_Mem_Byte_En,
  input  logic                      i_Mem_Resp_Valid,
  input  logic [DATA_WIDTH-1:0]     i_Mem_Rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   owner_mem;
  logic   grant_if, grant_mem;
  logic   if_force;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign if_force = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts MEM grants taken while IF was waiting; any IF grant resets it.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_mem && i_IF_Req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign if_force = 1'b0;
`endif

  // MEM holds the older instruction, so it wins ties unless IF is being starved.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      IDLE: begin
        if (i_MEM_Req && !(if_force && i_IF_Req)) begin
          grant_mem = 1'b1;
          state_nxt = ISSUE;
        end else if (i_IF_Req) begin
          grant_if  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (i_Mem_Ready) state_nxt = WAIT;
      WAIT:    if (i_Mem_Resp_Valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= IDLE;
      owner_mem     <= 1'b0;
      o_Mem_Write   <= 1'b0;
      o_Mem_Addr    <= '0;
      o_Mem_Wdata   <= '0;
      o_Mem_Byte_En <= '0;
      o_IF_Rdata    <= '0;
      o_MEM_Rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_mem) begin
        owner_mem     <= 1'b1;
        o_Mem_Write   <= i_MEM_Write;
        o_Mem_Addr    <= i_MEM_Addr;
        o_Mem_Wdata   <= i_MEM_Wdata;
        o_Mem_Byte_En <= i_MEM_Byte_En;
      end else if (grant_if) begin
        owner_mem     <= 1'b0;
        o_Mem_Write   <= 1'b0;
        o_Mem_Addr    <= i_IF_Addr;
        o_Mem_Wdata   <= '0;
        o_Mem_Byte_En <= '1;
      end
      // Write acks carry no data, so they leave the MEM read register alone.
      if (state == WAIT && i_Mem_Resp_Valid) begin
        if (owner_mem) begin
          if (!o_Mem_Write) o_MEM_Rdata <= i_Mem_Rdata;
        end else begin
          o_IF_Rdata <= i_Mem_Rdata;
        end
      end
    end
  end

  assign o_Mem_Valid = (state == ISSUE);
  assign o_IF_Done   = (state == DONE) && !owner_mem;
  assign o_MEM_Done  = (state == DONE) && owner_mem;

endmodule
